// File: rtl/layer_mem_arbiter_pkg.sv
// Shared definitions for the layer-memory arbiter: default widths, layer selects,
// requester IDs and the lock-owner state encoding.
package layer_mem_arbiter_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 13;

  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_OWN0 = 2'd1,
    LK_OWN1 = 2'd2
  } lock_state_e;

  function automatic lock_state_e own_state(input logic id);
    return (id == REQ_R1) ? LK_OWN1 : LK_OWN0;
  endfunction
endpackage

// File: rtl/layer_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with burst lock. Grant is combinational on the
// requests; lock owner and last winner are the only state.
module rr_arb2
  import layer_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);
  lock_state_e lk_q, lk_d;
  logic        last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      lk_q   <= LK_IDLE;
      last_q <= REQ_R1;
    end else begin
      lk_q   <= lk_d;
      last_q <= last_d;
    end
  end

  // A non-owner winning while the owner is idle leaves the lock untouched.
  always_comb begin
    lk_d   = lk_q;
    last_d = last_q;
    if (|gnt_o) begin
      last_d = gnt_o[1];
      if (lk_q == LK_IDLE || (lk_q == LK_OWN0 && gnt_o[0]) || (lk_q == LK_OWN1 && gnt_o[1]))
        lk_d = lock_i[gnt_o[1]] ? own_state(gnt_o[1]) : LK_IDLE;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    if (!reset) begin
      if (lk_q == LK_OWN0 && req_i[0])      gnt_o = 2'b01;
      else if (lk_q == LK_OWN1 && req_i[1]) gnt_o = 2'b10;
      else if (req_i == 2'b11)              gnt_o = last_q ? 2'b01 : 2'b10;
      else                                  gnt_o = req_i;
    end
  end
endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares the single layer-memory port between the conv/ReLU writer (R0) and the
// max-pool reader (R1); read data is routed back to whichever requester issued it.
module layer_mem_arbiter
  import layer_mem_arbiter_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          cwr,
  output logic          crd,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  output logic          csel,
  input  logic [DW-1:0] cdata_rd
);
  logic [1:0]         req, we, sel, lock, gnt, rvalid;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata, rdata_q;
  logic               win, rd_issue;

  assign req   = {r1_req, r0_req};
  assign we    = {r1_we, r0_we};
  assign sel   = {r1_sel, r0_sel};
  assign lock  = {r1_lock, r0_lock};
  assign addr  = {r1_addr, r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .lock_i(lock),
    .gnt_o (gnt)
  );

  assign r0_gnt   = gnt[0];
  assign r1_gnt   = gnt[1];
  assign win      = gnt[1];
  assign rd_issue = (|gnt) & ~we[win];

  logic          cwr_q, crd_q, csel_q;
  logic [AW-1:0] caddr_wr_q, caddr_rd_q;
  logic [DW-1:0] cdata_wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= CSEL_L0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      cwr_q <= (|gnt) & we[win];
      crd_q <= rd_issue;
      if (|gnt) begin
        csel_q <= sel[win];
        if (we[win]) begin
          caddr_wr_q <= addr[win];
          cdata_wr_q <= wdata[win];
        end else begin
          caddr_rd_q <= addr[win];
        end
      end
    end
  end

  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign csel     = csel_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;

  // Tag enters at the grant edge; stage RD_LAT lines up with memory data on cdata_rd.
  logic [RD_LAT:0] vld_pipe, own_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      rdata_q  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_issue};
      own_pipe <= {own_pipe[RD_LAT-1:0], win};
      if (rvalid[0]) rdata_q[0] <= cdata_rd;
      if (rvalid[1]) rdata_q[1] <= cdata_rd;
    end
  end

  assign rvalid[0] = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
  assign rvalid[1] = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];

  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_rdata  = rvalid[0] ? cdata_rd : rdata_q[0];
  assign r1_rdata  = rvalid[1] ? cdata_rd : rdata_q[1];
endmodule
